// File: rtl/window_gen_7x7.sv
// Raster-stream 7x7 window generator: six line buffers feed a 7x7 shift array,
// one strobe per interior pixel with centre coordinates and an end-of-frame pulse.
module window_gen_7x7 #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int PIX_W = 10
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             sof,
    input  logic [PIX_W-1:0]                 in_pixel,
    input  logic                             in_valid,
    output logic [48:0][PIX_W-1:0]           local_window,
    output logic                             local_window_valid,
    output logic [$clog2(IMG_W)-1:0]         center_x,
    output logic [$clog2(IMG_H)-1:0]         center_y,
    output logic                             frame_done
);
    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] ACTIVE = 1'b1;

    logic [0:0]              state_q, state_d;
    logic [XW-1:0]           col_q, col_d, pos_x;
    logic [YW-1:0]           row_q, row_d, pos_y;
    logic                    accept, last_col, last_row;
    logic [6:0][PIX_W-1:0]   new_col;
    logic [48:0][PIX_W-1:0]  win_q, win_d;
    logic                    vld_q, vld_d;
    logic [XW-1:0]           cx_q, cx_d;
    logic [YW-1:0]           cy_q, cy_d;
    logic                    done_q, done_d;

    // lb_mem[0] holds line y-6, lb_mem[5] holds line y-1 at each column.
    logic [PIX_W-1:0] lb_mem [0:5][0:IMG_W-1];

    always_comb begin
        accept   = in_valid && (sof || (state_q == ACTIVE));
        // A sof pixel is always (0,0), regardless of where the counters stand.
        pos_x    = sof ? '0 : col_q;
        pos_y    = sof ? '0 : row_q;
        last_col = (pos_x == XW'(IMG_W - 1));
        last_row = (pos_y == YW'(IMG_H - 1));

        for (int r = 0; r < 6; r++) new_col[r] = lb_mem[r][pos_x];
        new_col[6] = in_pixel;

        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        win_d   = win_q;
        vld_d   = 1'b0;
        cx_d    = cx_q;
        cy_d    = cy_q;
        done_d  = 1'b0;

        if (accept) begin
            state_d = ACTIVE;
            col_d   = last_col ? '0 : pos_x + 1'b1;
            row_d   = pos_y;
            if (last_col) row_d = last_row ? '0 : pos_y + 1'b1;
            if (last_col && last_row) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end

            for (int r = 0; r < 7; r++) begin
                for (int c = 0; c < 6; c++) win_d[r*7+c] = win_q[r*7+c+1];
                win_d[r*7+6] = new_col[r];
            end

            if ((pos_x >= XW'(6)) && (pos_y >= YW'(6))) begin
                vld_d = 1'b1;
                cx_d  = pos_x - XW'(3);
                cy_d  = pos_y - YW'(3);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            col_q   <= '0;
            row_q   <= '0;
            win_q   <= '0;
            vld_q   <= 1'b0;
            cx_q    <= '0;
            cy_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            win_q   <= win_d;
            vld_q   <= vld_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            done_q  <= done_d;
        end
    end

    // Line-buffer contents need no reset; windows only form from freshly written lines.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int r = 0; r < 6; r++) lb_mem[r][pos_x] <= new_col[r+1];
        end
    end

    assign local_window       = win_q;
    assign local_window_valid = vld_q;
    assign center_x           = cx_q;
    assign center_y           = cy_q;
    assign frame_done         = done_q;
endmodule

// File: doc/window_gen_7x7.md
Name: window_gen_7x7

Overview:
- Upstream neighbour of the range-kernel stage.
- Takes a raster-order pixel stream and builds a 7x7 local window of PIX_W-bit pixels from 6 line buffers and a 7x7 register array.
- Emits one window per interior pixel, centre at local_window[24], plus a window-valid strobe.
- Also reports the centre coordinates and a frame-done pulse for the downstream weighting/normalisation stages.

Parameters:
- IMG_W, 640, pixels per line (>= 7).
- IMG_H, 480, lines per frame (>= 7).
- PIX_W, 10, pixel bit width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- sof  in  1  start-of-frame; qualified by in_valid; marks pixel (0,0).
- in_pixel  in  PIX_W  input pixel, raster order.
- in_valid  in  1  in_pixel valid this cycle; the block always accepts (no backpressure).
- local_window  out  49 x PIX_W  window; index r*7+c.
- local_window_valid  out  1  window valid, single-cycle strobe.
- center_x  out  clog2(IMG_W)  column of window centre.
- center_y  out  clog2(IMG_H)  row of window centre.
- frame_done  out  1  single-cycle pulse after the last pixel of the frame.

Behaviour:
- Reset (async assert, sync deassert): all outputs 0; col/row counters 0; state IDLE. Line-buffer contents are don't-care.
- FSM, IDLE:
  - Pixels with in_valid=1 and sof=0 are ignored.
  - in_valid=1 with sof=1 is accepted as pixel (0,0); go to ACTIVE.
- FSM, ACTIVE:
  - Each in_valid=1 pixel is accepted; col increments.
  - col wraps IMG_W-1 -> 0 and row increments.
  - Accepting pixel (IMG_W-1, IMG_H-1): pulse frame_done the next cycle; go to IDLE.
- sof=1 with in_valid=1 while ACTIVE: frame restarts. That pixel is (0,0), counters reset, and no window from the aborted frame is emitted afterwards.
- Line buffers:
  - 6 buffers of IMG_W x PIX_W.
  - On each accepted pixel at column col: column col of the buffers shifts up one line, and in_pixel enters the bottom.
  - This yields a 7-pixel vertical column: rows y-6..y.
- Window array:
  - On each accepted pixel, the 7x7 array shifts left one column; the new column enters at c=6.
  - r=0 is the oldest row (y-6), r=6 is the current row.
  - c=0 is the oldest column (x-6), c=6 is the current column.
- Window valid:
  - Accepting pixel (x,y) with x>=6 and y>=6 completes the window centred at (x-3,y-3).
  - local_window_valid=1 exactly one cycle after that accept, with center_x=x-3, center_y=y-3.
  - Latency is 1 clk from the completing in_valid to local_window_valid.
- Border pixels (centre within 3 of any edge) produce no window. Each frame yields exactly (IMG_W-6)*(IMG_H-6) strobes.
- The row-wrap column reload requires no special handling: a window is only valid once 7 columns of the current line have been accepted.
- Stall: in_valid=0 cycles freeze counters, buffers and array; local_window_valid=0. local_window holds its last value.
- local_window is stable and valid only in the cycle local_window_valid=1; the downstream stage samples it on that strobe.
- Back-to-back in_valid produces back-to-back strobes: full throughput, one window per clk.
- Last-pixel coincidence: frame_done and the final local_window_valid assert in the same cycle.
- Arithmetic: unsigned pass-through of pixel values; no truncation or padding.

Test Plan:
- Basic frame:
  - Stimulus: IMG_W=IMG_H=8, continuous in_valid, sof on the first pixel, pixel value = y*8+x.
  - Response: first strobe one cycle after the 55th pixel, with window[0]=0, window[24]=27, window[48]=54, center=(3,3).
  - Exactly 4 strobes; frame_done in the same cycle as the 4th strobe.
- Random gaps:
  - Stimulus: same frame with random in_valid gaps (~40% idle).
  - Response: identical window contents and coordinate sequence as the basic frame; strobes only one cycle after an accept.
- Mid-frame restart:
  - Stimulus: sof mid-frame at pixel (5,6), then a full new frame with values +100.
  - Response: no stale windows; first window has window[24]=127 and center (3,3).
- IDLE rejection:
  - Stimulus: in_valid pixels with no sof after reset.
  - Response: no strobes, no frame_done.
  - Then sof: normal behaviour resumes.
- Reset mid-frame:
  - Stimulus: rst_n low for 2 cycles while ACTIVE.
  - Response: outputs 0 immediately (async).
  - Next frame after sof matches the basic-frame results exactly.
- Back-to-back frames:
  - Stimulus: two 8x8 frames with sof immediately after the last pixel.
  - Response: 8 strobes total; two frame_done pulses; second-frame windows contain no first-frame pixels.
